// File: rtl/aes_pkg.sv
// Shared constants and index helpers for the AES ShiftRows datapath.
// All helpers are evaluated at elaboration time to build fixed byte wiring.
package aes_pkg;

  localparam int BYTE_W = 32'sd8;
  localparam int COL_W  = 32'sd32;
  localparam int ROWS   = 32'sd4;

  // Rotation amount C_r of state row `row` for a block of `nb` columns.
  // Rijndael uses (0,1,2,3) up to six columns and (0,1,3,4) for eight.
  function automatic int shift_offset(input int nb, input int row);
    int off;
    case (row)
      32'sd0:  off = 32'sd0;
      32'sd1:  off = 32'sd1;
      32'sd2:  off = (nb == 32'sd8) ? 32'sd3 : 32'sd2;
      32'sd3:  off = (nb == 32'sd8) ? 32'sd4 : 32'sd3;
      default: off = 32'sd0;
    endcase
    return off;
  endfunction

  // Source column for output column `c` of a row rotated by `off`.
  // Forward rotates left (c+off), inverse rotates right (c-off+nb).
  // Both sums lie in [0, 2*nb), so one conditional subtract reduces them,
  // which also wraps correctly for the non-power-of-two width nb=6.
  function automatic int col_idx(input int c, input int off, input int nb, input logic inv);
    int idx;
    if (inv) begin
      idx = c - off + nb;
    end else begin
      idx = c + off;
    end
    if (idx >= nb) begin
      idx = idx - nb;
    end else begin
      idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle of the ShiftRows pipe: input stream, output stream, busy.
// `slave` is the unit's view, `master` the view of whoever drives and drains it.
interface shift_rows_pipe_if
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [COL_W*NB-1:0]   in_data;
  logic                  in_inv;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [COL_W*NB-1:0]   out_data;
  logic [TAG_W-1:0]      out_tag;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/pipe_stage.sv
// One valid/ready register slice. The slot loads when it is empty or its
// contents leave this cycle; the ready seen upstream is formed by the parent
// from the same rule so the whole chain is computed in one place.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         dn_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data
);
  logic         load_s;
  logic         valid_r;
  logic [W-1:0] data_r;

  assign load_s = !valid_r || dn_ready;

  // Occupancy flag: the only reset state; follows upstream valid whenever the slot can load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= up_valid;
    end
  end

  // Payload captured only on a real transfer, so a stalled slot holds its contents.
  always_ff @(posedge clk) begin
    if (load_s && up_valid) begin
      data_r <= up_data;
    end
  end

  assign dn_valid = valid_r;
  assign dn_data  = data_r;
endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows for 4, 6 or 8 column Rijndael states.
// The byte permutation is pure wiring muxed by in_inv in front of the first
// slice; STAGES slices follow, with a ready chain that lets bubbles collapse.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input logic              clk,
  input logic              rst,
  shift_rows_pipe_if.slave bus
);
  localparam int DATA_W = COL_W * NB;
  localparam int PAY_W  = TAG_W + DATA_W;

  if (!(NB == 32'sd4 || NB == 32'sd6 || NB == 32'sd8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8, got %0d", NB);
  end
  if (STAGES < 32'sd1 || STAGES > 32'sd4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be in 1..4, got %0d", STAGES);
  end

  logic [DATA_W-1:0] perm_s;
  logic [STAGES:0]   valid_s;
  logic [STAGES:0]   rdy_s;
  logic [PAY_W-1:0]  pay_s [0:STAGES];

  // Byte (r,c) lives at bit COL_W*(NB-1-c) + COL_W-1 - BYTE_W*r. Both the
  // forward and inverse sources are wired and in_inv picks per block.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int OFF   = shift_offset(NB, r);
      localparam int SRC_F = col_idx(c, OFF, NB, 1'b0);
      localparam int SRC_I = col_idx(c, OFF, NB, 1'b1);
      localparam int DST   = COL_W * (NB - 1 - c)     + COL_W - 1 - BYTE_W * r;
      localparam int BIT_F = COL_W * (NB - 1 - SRC_F) + COL_W - 1 - BYTE_W * r;
      localparam int BIT_I = COL_W * (NB - 1 - SRC_I) + COL_W - 1 - BYTE_W * r;
      assign perm_s[DST -: BYTE_W] = bus.in_inv ? bus.in_data[BIT_I -: BYTE_W]
                                                : bus.in_data[BIT_F -: BYTE_W];
    end
  end

  assign valid_s[0] = bus.in_valid;
  assign pay_s[0]   = {bus.in_tag, perm_s};

  // Ready chain from the tail back: slot i+1 accepts if it is empty or slot i+2 accepts.
  always_comb begin
    rdy_s         = {(STAGES + 1){1'b0}};
    rdy_s[STAGES] = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy_s[i] = !valid_s[i + 1] || rdy_s[i + 1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    pipe_stage #(.W(PAY_W)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (valid_s[s]),
      .up_data  (pay_s[s]),
      .dn_ready (rdy_s[s + 1]),
      .dn_valid (valid_s[s + 1]),
      .dn_data  (pay_s[s + 1])
    );
  end

  assign bus.in_ready  = rdy_s[0];
  assign bus.out_valid = valid_s[STAGES];
  assign bus.out_data  = pay_s[STAGES][DATA_W-1:0];
  assign bus.out_tag   = pay_s[STAGES][PAY_W-1:DATA_W];
  assign bus.busy      = |valid_s[STAGES:1];
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed plus randomized bench for shift_rows_pipe: three instances
// (NB=4/STAGES=1, NB=8/STAGES=2, NB=6/STAGES=3) checked against a byte-matrix
// reference that rotates each state row by its Rijndael offset.
module tb_shift_rows_pipe;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  typedef struct {
    logic [191:0] d;
    logic [3:0]   t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shift_rows_pipe_if #(.NB(4), .TAG_W(4)) b4 ();
  shift_rows_pipe_if #(.NB(8), .TAG_W(4)) b8 ();
  shift_rows_pipe_if #(.NB(6), .TAG_W(4)) b6 ();

  shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) d4 (.clk(clk), .rst(rst), .bus(b4.slave));
  shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) d8 (.clk(clk), .rst(rst), .bus(b8.slave));
  shift_rows_pipe #(.NB(6), .STAGES(3), .TAG_W(4)) d6 (.clk(clk), .rst(rst), .bus(b6.slave));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: unpack into a 4 x nb byte matrix, rotate every row, repack.
  function automatic logic [255:0] ref_rows(input int nb, input logic [255:0] d, input logic inv);
    logic [7:0]   st [4][8];
    logic [255:0] o;
    int           k;
    int           s;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        st[r][c] = d[32*(nb-1-c) + 31 - 8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      k = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        s = inv ? (c + nb - k) % nb : (c + k) % nb;
        o[32*(nb-1-c) + 31 - 8*r -: 8] = st[r][s];
      end
    end
    return o;
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    logic [255:0] r, ra, rb, rc, seq, res, prev;
    logic         prev_inv;
    logic [191:0] blk [20];
    logic [191:0] hold_d;
    logic [3:0]   hold_t;
    logic         stall_q;
    exp_t         sb [$];
    exp_t         e;
    int           sent, got, cyc;

    rst = 1'b1;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_inv = 1'b0; b4.in_tag = 4'h0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_inv = 1'b0; b8.in_tag = 4'h0; b8.out_ready = 1'b1;
    b6.in_valid = 1'b0; b6.in_data = '0; b6.in_inv = 1'b0; b6.in_tag = 4'h0; b6.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk_bit("rst_held_out_valid4", b4.out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_bit("rst_in_ready4", b4.in_ready, 1'b1);
    chk_bit("rst_out_valid4", b4.out_valid, 1'b0);
    chk_bit("rst_busy4", b4.busy, 1'b0);
    chk_bit("rst_in_ready8", b8.in_ready, 1'b1);
    chk_bit("rst_busy8", b8.busy, 1'b0);
    chk_bit("rst_out_valid6", b6.out_valid, 1'b0);
    chk_bit("rst_busy6", b6.busy, 1'b0);

    // NB=4 FIPS-197 forward vector, one-cycle latency
    b4.in_valid = 1'b1; b4.in_data = FIPS_IN; b4.in_inv = 1'b0; b4.in_tag = 4'h5;
    #1 chk_bit("fips_fwd_in_ready", b4.in_ready, 1'b1);
    @(negedge clk);
    b4.in_valid = 1'b0;
    chk_bit("fips_fwd_valid", b4.out_valid, 1'b1);
    chk("fips_fwd_data", 256'(b4.out_data), 256'(FIPS_OUT));
    chk("fips_fwd_ref", 256'(b4.out_data), ref_rows(4, 256'(FIPS_IN), 1'b0));
    chk("fips_fwd_tag", 256'(b4.out_tag), 256'(4'h5));

    // NB=4 inverse vector
    b4.in_valid = 1'b1; b4.in_data = FIPS_OUT; b4.in_inv = 1'b1; b4.in_tag = 4'ha;
    @(negedge clk);
    b4.in_valid = 1'b0;
    chk_bit("fips_inv_valid", b4.out_valid, 1'b1);
    chk("fips_inv_data", 256'(b4.out_data), 256'(FIPS_IN));
    chk("fips_inv_tag", 256'(b4.out_tag), 256'(4'ha));
    @(negedge clk);
    chk_bit("fips_drained", b4.out_valid, 1'b0);

    // NB=4 back-to-back random blocks with alternating mode: one per cycle
    prev = '0; prev_inv = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        chk_bit("stream4_valid", b4.out_valid, 1'b1);
        chk("stream4_data", 256'(b4.out_data), ref_rows(4, prev, prev_inv));
        chk("stream4_tag", 256'(b4.out_tag), 256'(4'(i - 1)));
      end
      if (i < 8) begin
        r = rnd();
        prev = 256'(r[127:0]); prev_inv = i[0];
        b4.in_valid = 1'b1; b4.in_data = r[127:0]; b4.in_inv = i[0]; b4.in_tag = 4'(i);
        #1 chk_bit("stream4_in_ready", b4.in_ready, 1'b1);
      end else begin
        b4.in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // NB=8 ordered bytes, forward, two-cycle latency
    seq = '0;
    for (int c = 0; c < 8; c++)
      for (int q = 0; q < 4; q++)
        seq[32*(7-c) + 31 - 8*q -: 8] = 8'(4*c + q);
    b8.in_valid = 1'b1; b8.in_data = seq; b8.in_inv = 1'b0; b8.in_tag = 4'h1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    chk_bit("nb8_latency_not_yet", b8.out_valid, 1'b0);
    @(negedge clk);
    chk_bit("nb8_fwd_valid", b8.out_valid, 1'b1);
    res = b8.out_data;
    chk("nb8_r3c0", 256'(res[231 -: 8]), 256'(8'h13));
    chk("nb8_r2c7", 256'(res[15 -: 8]), 256'(8'h0a));
    chk("nb8_fwd_ref", res, ref_rows(8, seq, 1'b0));
    b8.in_valid = 1'b1; b8.in_data = res; b8.in_inv = 1'b1; b8.in_tag = 4'h2;
    @(negedge clk);
    b8.in_valid = 1'b0;
    @(negedge clk);
    chk_bit("nb8_inv_valid", b8.out_valid, 1'b1);
    chk("nb8_roundtrip", 256'(b8.out_data), seq);
    chk("nb8_inv_tag", 256'(b8.out_tag), 256'(4'h2));
    @(negedge clk);

    // STAGES=2 backpressure: fill, stall the third, then pop and push together
    ra = rnd(); rb = rnd(); rc = rnd();
    b8.out_ready = 1'b0;
    b8.in_valid = 1'b1; b8.in_data = ra; b8.in_inv = 1'b0; b8.in_tag = 4'h2;
    #1 chk_bit("bp_a_ready", b8.in_ready, 1'b1);
    @(negedge clk);
    b8.in_data = rb; b8.in_inv = 1'b1; b8.in_tag = 4'h3;
    #1 chk_bit("bp_b_ready", b8.in_ready, 1'b1);
    @(negedge clk);
    b8.in_data = rc; b8.in_inv = 1'b0; b8.in_tag = 4'h4;
    #1 chk_bit("bp_c_blocked", b8.in_ready, 1'b0);
    chk_bit("bp_busy", b8.busy, 1'b1);
    chk_bit("bp_out_valid", b8.out_valid, 1'b1);
    chk("bp_head_data", 256'(b8.out_data), ref_rows(8, ra, 1'b0));
    @(negedge clk);
    chk_bit("bp_still_blocked", b8.in_ready, 1'b0);
    chk("bp_head_stable", 256'(b8.out_data), ref_rows(8, ra, 1'b0));
    b8.out_ready = 1'b1;
    #1 chk_bit("bp_ready_follows_out_ready", b8.in_ready, 1'b1);
    @(negedge clk);
    b8.in_valid = 1'b0;
    chk("bp_b_data", 256'(b8.out_data), ref_rows(8, rb, 1'b1));
    chk("bp_b_tag", 256'(b8.out_tag), 256'(4'h3));
    @(negedge clk);
    chk_bit("bp_c_valid", b8.out_valid, 1'b1);
    chk("bp_c_data", 256'(b8.out_data), ref_rows(8, rc, 1'b0));
    chk("bp_c_tag", 256'(b8.out_tag), 256'(4'h4));
    @(negedge clk);
    chk_bit("bp_empty", b8.busy, 1'b0);

    // NB=6 STAGES=3: 20 random blocks, random output stalls, scoreboard order
    for (int i = 0; i < 20; i++) begin
      r = rnd();
      blk[i] = r[191:0];
    end
    sent = 0; got = 0; cyc = 0; stall_q = 1'b0; hold_d = '0; hold_t = 4'h0;
    while (got < 20 && cyc < 400) begin
      cyc++;
      if (stall_q) begin
        chk_bit("rnd_stall_valid", b6.out_valid, 1'b1);
        chk("rnd_stall_data", 256'(b6.out_data), 256'(hold_d));
        chk("rnd_stall_tag", 256'(b6.out_tag), 256'(hold_t));
      end
      b6.out_ready = 1'($urandom_range(0, 1));
      b6.in_valid  = (sent < 20);
      if (sent < 20) begin
        b6.in_data = blk[sent]; b6.in_inv = sent[0]; b6.in_tag = 4'(sent % 16);
      end
      #1;
      if (b6.out_valid && b6.out_ready) begin
        chk_bit("rnd_no_extra", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rnd_data", 256'(b6.out_data), 256'(e.d));
          chk("rnd_tag", 256'(b6.out_tag), 256'(e.t));
          got++;
        end
      end
      if (b6.in_valid && b6.in_ready) begin
        r = ref_rows(6, 256'(blk[sent]), sent[0]);
        e.d = r[191:0]; e.t = 4'(sent % 16);
        sb.push_back(e);
        sent++;
      end
      stall_q = b6.out_valid && !b6.out_ready;
      hold_d  = b6.out_data;
      hold_t  = b6.out_tag;
      @(negedge clk);
    end
    b6.in_valid = 1'b0;
    chk("rnd_received", 256'(got), 256'(20));
    chk("rnd_sent", 256'(sent), 256'(20));
    chk("rnd_sb_empty", 256'(sb.size()), 256'(0));
    b6.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk_bit("rnd_no_dup", b6.out_valid, 1'b0);
    chk_bit("rnd_idle", b6.busy, 1'b0);

    // Asynchronous reset with two blocks in flight
    ra = rnd(); rb = rnd();
    b6.out_ready = 1'b0;
    b6.in_valid = 1'b1; b6.in_data = ra[191:0]; b6.in_inv = 1'b0; b6.in_tag = 4'h7;
    @(negedge clk);
    b6.in_data = rb[191:0]; b6.in_tag = 4'h8;
    @(negedge clk);
    b6.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_bit("arst_pre_valid", b6.out_valid, 1'b1);
    chk_bit("arst_pre_busy", b6.busy, 1'b1);
    r = ref_rows(6, 256'(ra[191:0]), 1'b0);
    chk("arst_pre_data", 256'(b6.out_data), r);
    #2 rst = 1'b1;
    #1;
    chk_bit("arst_out_valid_drop", b6.out_valid, 1'b0);
    chk_bit("arst_busy_drop", b6.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_bit("arst_in_ready", b6.in_ready, 1'b1);
    chk_bit("arst_out_valid_after", b6.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
